// File: rtl/prbs_qam_src.sv
//----------------------------------------------------------------------------
// prbs_qam_src
//
// PRBS symbol source for the DSP test chain. A phase accumulator produces a
// fractional-rate bit tick; each tick advances a selectable-length Fibonacci
// LFSR. Emitted bits are packed into BPSK/QPSK/16QAM/64QAM symbols (optional
// Gray-coded per-axis index) and presented to the pulse-shaping filter over a
// valid/ready handshake with a sticky overflow flag.
//
// Optional feature macro: PRBS_ERR_INJ_EN
//   defined   : err_inj port exists; a pulse inverts the next emitted bit.
//   undefined : no err_inj port, no inversion logic.
//
// Parameters
//   WIDTH  signed I/Q sample width (4..16)
//   ACC_W  rate accumulator width (8..32)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   en              run enable, gates the accumulator
//   rate            accumulator increment (bit rate = f_clk*rate/2^ACC_W)
//   pn_sel          polynomial: 0 PN7, 1 PN9, 2 PN11, 3 PN15, 4 PN23,
//                   5 PN31, 6/7 PN7
//   mod_sel         0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM
//   gray            1 = per-axis index is Gray coded
//   err_inj         error-insert pulse (PRBS_ERR_INJ_EN only)
//   bit_out         emitted PRBS bit, qualified by bit_valid
//   bit_valid       one-cycle strobe, one cycle after the carry cycle
//   pat_sync        strobe on the first bit of each PRBS period
//   i_out, q_out    signed symbol levels
//   sym_valid       symbol available
//   sym_ready       downstream accepts the symbol
//   overflow        sticky: a completed symbol was dropped
//----------------------------------------------------------------------------
module prbs_qam_src #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ACC_W-1:0]        rate,
  input  logic [2:0]              pn_sel,
  input  logic [1:0]              mod_sel,
  input  logic                    gray,
`ifdef PRBS_ERR_INJ_EN
  input  logic                    err_inj,
`endif
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    pat_sync,
  output logic signed [WIDTH-1:0] i_out,
  output logic signed [WIDTH-1:0] q_out,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    overflow
);

  //--------------------------------------------------------------------------
  // Level constants. Levels are (2m-(M-1))*scale with
  // scale = floor((2^(WIDTH-1)-1)/(M-1)); the product always fits in
  // WIDTH bits, the extra 4 bits only keep the intermediate exact.
  //--------------------------------------------------------------------------
  localparam int LW = WIDTH + 4;
  localparam int FULL_SCALE = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [LW-1:0] SCALE2 = LW'(FULL_SCALE);
  localparam logic signed [LW-1:0] SCALE4 = LW'(FULL_SCALE / 3);
  localparam logic signed [LW-1:0] SCALE8 = LW'(FULL_SCALE / 7);
  localparam logic signed [LW-1:0] ONE    = LW'(1);
  localparam logic signed [LW-1:0] THREE  = LW'(3);
  localparam logic signed [LW-1:0] SEVEN  = LW'(7);

  // Axis level for index m with ka bits per axis (ka = 1, 2 or 3).
  function automatic logic signed [WIDTH-1:0] level_of(
    input logic [2:0] m,
    input logic [1:0] ka
  );
    logic signed [LW-1:0] twice_m;
    logic signed [LW-1:0] odd;
    logic signed [LW-1:0] prod;
    twice_m = $signed({{WIDTH{1'b0}}, m, 1'b0});
    case (ka)
      2'd1: begin
        odd  = twice_m - ONE;
        prod = odd * SCALE2;
      end
      2'd2: begin
        odd  = twice_m - THREE;
        prod = odd * SCALE4;
      end
      default: begin
        odd  = twice_m - SEVEN;
        prod = odd * SCALE8;
      end
    endcase
    return prod[WIDTH-1:0];
  endfunction

  // Gray-to-binary on a zero-extended index; leading zeros do not change
  // the conversion, so one 3-bit function serves every constellation.
  function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  //--------------------------------------------------------------------------
  // Rate accumulator: the carry out of acc + rate is the bit tick.
  //--------------------------------------------------------------------------
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             bit_tick;

  assign acc_sum  = {1'b0, acc} + {1'b0, rate};
  assign bit_tick = en & acc_sum[ACC_W];

  //--------------------------------------------------------------------------
  // Registered configuration. A difference between the live inputs and the
  // registered copy restarts the pattern; the tick of that cycle is dropped
  // so the first bit afterwards is the first bit of the new sequence.
  //--------------------------------------------------------------------------
  logic [2:0] pn_r;
  logic [1:0] mod_r;
  logic       gray_r;
  logic       cfg_chg;
  logic       tick_eff;

  assign cfg_chg  = (pn_sel != pn_r) | (mod_sel != mod_r) | (gray != gray_r);
  assign tick_eff = bit_tick & ~cfg_chg;

  //--------------------------------------------------------------------------
  // LFSR taps and period length for the selected polynomial.
  //--------------------------------------------------------------------------
  logic [30:0] lfsr;
  logic [30:0] pcnt;
  logic [30:0] pcnt_max;
  logic        fb;

  always_comb begin
    fb       = lfsr[6] ^ lfsr[5];
    pcnt_max = 31'd126;
    case (pn_r)
      3'd1: begin
        fb       = lfsr[8] ^ lfsr[4];
        pcnt_max = 31'd510;
      end
      3'd2: begin
        fb       = lfsr[10] ^ lfsr[8];
        pcnt_max = 31'd2046;
      end
      3'd3: begin
        fb       = lfsr[14] ^ lfsr[13];
        pcnt_max = 31'd32766;
      end
      3'd4: begin
        fb       = lfsr[22] ^ lfsr[17];
        pcnt_max = 31'd8388606;
      end
      3'd5: begin
        fb       = lfsr[30] ^ lfsr[27];
        pcnt_max = 31'h7FFF_FFFE;
      end
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Error insertion: a pending request (or a pulse in the tick cycle itself)
  // inverts the emitted bit only; the LFSR keeps the true feedback.
  //--------------------------------------------------------------------------
  logic inv;

`ifdef PRBS_ERR_INJ_EN
  logic err_pend;

  assign inv = err_pend | err_inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend <= 1'b0;
    end else if (tick_eff) begin
      err_pend <= 1'b0;
    end else if (err_inj) begin
      err_pend <= 1'b1;
    end
  end
`else
  assign inv = 1'b0;
`endif

  logic emit;
  assign emit = fb ^ inv;

  //--------------------------------------------------------------------------
  // Symbol packing. sym_sr holds the bits already received for the current
  // symbol, oldest in the highest used position, so {sym_sr, emit} has the
  // first bit of the symbol at position k-1 when the last bit arrives.
  //--------------------------------------------------------------------------
  logic [2:0] bcnt;
  logic [4:0] sym_sr;
  logic [5:0] word;
  logic [2:0] k_m1;
  logic [1:0] ka;
  logic [2:0] i_bits;
  logic [2:0] q_bits;
  logic [2:0] i_idx;
  logic [2:0] q_idx;
  logic signed [WIDTH-1:0] i_lvl;
  logic signed [WIDTH-1:0] q_lvl;

  assign word = {sym_sr, emit};

  always_comb begin
    k_m1   = 3'd0;
    ka     = 2'd1;
    i_bits = {2'b00, word[0]};
    q_bits = 3'd0;
    case (mod_r)
      2'd1: begin
        k_m1   = 3'd1;
        ka     = 2'd1;
        i_bits = {2'b00, word[1]};
        q_bits = {2'b00, word[0]};
      end
      2'd2: begin
        k_m1   = 3'd3;
        ka     = 2'd2;
        i_bits = {1'b0, word[3:2]};
        q_bits = {1'b0, word[1:0]};
      end
      2'd3: begin
        k_m1   = 3'd5;
        ka     = 2'd3;
        i_bits = word[5:3];
        q_bits = word[2:0];
      end
      default: ;
    endcase
  end

  assign i_idx = gray_r ? gray_to_bin(i_bits) : i_bits;
  assign q_idx = gray_r ? gray_to_bin(q_bits) : q_bits;
  assign i_lvl = level_of(i_idx, ka);
  // BPSK carries no quadrature component.
  assign q_lvl = (mod_r == 2'd0) ? '0 : level_of(q_idx, ka);

  //--------------------------------------------------------------------------
  // Output handshake. sym_valid/i_out/q_out form a standard valid/ready
  // register: a transfer happens on a rising clk with sym_valid & sym_ready;
  // while sym_valid & !sym_ready the payload holds stable. A completed symbol
  // loads when the register is empty or being emptied in the same cycle,
  // otherwise it is dropped and overflow latches until rst.
  //--------------------------------------------------------------------------
  logic sym_done;
  logic sym_load;
  logic sym_drop;

  assign sym_done = tick_eff & (bcnt == k_m1);
  assign sym_load = sym_done & (~sym_valid | sym_ready);
  assign sym_drop = sym_done & sym_valid & ~sym_ready;

  //--------------------------------------------------------------------------
  // Main state.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      pn_r      <= pn_sel;
      mod_r     <= mod_sel;
      gray_r    <= gray;
      lfsr      <= '1;
      pcnt      <= '0;
      bcnt      <= '0;
      sym_sr    <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      pat_sync  <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      sym_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pn_r      <= pn_sel;
      mod_r     <= mod_sel;
      gray_r    <= gray;
      bit_valid <= tick_eff;
      pat_sync  <= tick_eff & (pcnt == '0);

      if (en) begin
        acc <= acc_sum[ACC_W-1:0];
      end

      if (cfg_chg) begin
        lfsr   <= '1;
        pcnt   <= '0;
        bcnt   <= '0;
        sym_sr <= '0;
      end else if (bit_tick) begin
        lfsr    <= {lfsr[29:0], fb};
        bit_out <= emit;
        pcnt    <= (pcnt == pcnt_max) ? '0 : pcnt + 31'd1;
        bcnt    <= sym_done ? 3'd0 : bcnt + 3'd1;
        sym_sr  <= {sym_sr[3:0], emit};
      end

      if (sym_load) begin
        i_out     <= i_lvl;
        q_out     <= q_lvl;
        sym_valid <= 1'b1;
      end else if (sym_valid & sym_ready) begin
        sym_valid <= 1'b0;
      end

      if (sym_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_qam_src.sv
//----------------------------------------------------------------------------
// tb_prbs_qam_src
//
// Directed scenarios plus randomized segments for prbs_qam_src. The reference
// model regenerates the PRBS from its recurrence x[k] = x[k-n] ^ x[k-t] on a
// bit history, packs bits into symbols with integer arithmetic, and tracks the
// output register occupancy to predict loads, drops and overflow.
//----------------------------------------------------------------------------
module tb_prbs_qam_src;
  localparam int WIDTH = 16;
  localparam int ACC_W = 24;
  localparam longint ACC_MASK = (longint'(1) << ACC_W) - 1;

  // Clock / reset and stimulus signals
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [ACC_W-1:0] rate = '0;
  logic [2:0] pn_sel = 3'd0;
  logic [1:0] mod_sel = 2'd0;
  logic gray = 1'b0;
  logic err_inj = 1'b0;
  logic sym_ready = 1'b1;

  logic bit_out, bit_valid, pat_sync, sym_valid, overflow;
  logic signed [WIDTH-1:0] i_out, q_out;

  always #5 clk = ~clk;

  prbs_qam_src #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rate      (rate),
    .pn_sel    (pn_sel),
    .mod_sel   (mod_sel),
    .gray      (gray),
`ifdef PRBS_ERR_INJ_EN
    .err_inj   (err_inj),
`endif
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .pat_sync  (pat_sync),
    .i_out     (i_out),
    .q_out     (q_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .overflow  (overflow)
  );

  // Counters
  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  longint acc_m;
  logic [2:0] pn_c;
  logic [1:0] mod_c;
  logic gray_c;
  bit hist[$];
  bit part[$];
  longint cnt_m;
  int n_m, t_m;
  logic exp_bv, exp_bo, exp_ps, mv, ovf_m;
  bit pend_m;
  logic [2*WIDTH-1:0] exp_q[$];

  // Observation records
  bit raw_q[$];
  bit obs_bits[$];
  int ps_idx[$];
  int bv_count;
  logic [WIDTH-1:0] acc_i[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic void taps(input logic [2:0] pn, output int n, output int t);
    case (pn)
      3'd1: begin n = 9;  t = 5;  end
      3'd2: begin n = 11; t = 9;  end
      3'd3: begin n = 15; t = 14; end
      3'd4: begin n = 23; t = 18; end
      3'd5: begin n = 31; t = 28; end
      default: begin n = 7; t = 6; end
    endcase
  endfunction

  function automatic int bits_per(input logic [1:0] m);
    case (m)
      2'd1: return 2;
      2'd2: return 4;
      2'd3: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic int level(input int m, input int mm);
    int scale;
    scale = ((1 << (WIDTH - 1)) - 1) / (mm - 1);
    return (2 * m - (mm - 1)) * scale;
  endfunction

  function automatic logic [2*WIDTH-1:0] make_symbol();
    int k, ka, mm, mi, mq, li, lq;
    bit ri, rq;
    logic [WIDTH-1:0] wi, wq;
    k = part.size();
    ka = (k == 1) ? 1 : k / 2;
    mm = 1 << ka;
    mi = 0; mq = 0; ri = 0; rq = 0;
    for (int j = 0; j < ka; j++) begin
      ri ^= part[j];
      mi = mi * 2 + int'(gray_c ? ri : part[j]);
      if (k > 1) begin
        rq ^= part[ka + j];
        mq = mq * 2 + int'(gray_c ? rq : part[ka + j]);
      end
    end
    li = level(mi, mm);
    lq = (k == 1) ? 0 : level(mq, mm);
    wi = WIDTH'(li);
    wq = WIDTH'(lq);
    return {wi, wq};
  endfunction

  task automatic restart_seq();
    taps(pn_c, n_m, t_m);
    hist.delete();
    repeat (n_m) hist.push_back(1'b1);
    cnt_m = 0;
    part.delete();
  endtask

  // Predicts the DUT state after the coming rising edge from current inputs.
  task automatic model_step();
    logic chg, tick, inj, inv, done, acc_now;
    bit e, b;
    longint sum;
    logic [2*WIDTH-1:0] sym;
    inj = 1'b0;
`ifdef PRBS_ERR_INJ_EN
    inj = err_inj;
`endif
    if (rst) begin
      acc_m = 0;
      pn_c = pn_sel; mod_c = mod_sel; gray_c = gray;
      restart_seq();
      exp_bv = 0; exp_bo = 0; exp_ps = 0;
      mv = 0; ovf_m = 0; pend_m = 0;
      exp_q.delete();
      return;
    end
    chg = (pn_sel != pn_c) || (mod_sel != mod_c) || (gray != gray_c);
    pn_c = pn_sel; mod_c = mod_sel; gray_c = gray;
    tick = 1'b0;
    if (en) begin
      sum = acc_m + longint'(rate);
      tick = (sum >> ACC_W) != 0;
      acc_m = sum & ACC_MASK;
    end
    inv = pend_m | inj;
    exp_bv = 0; exp_ps = 0; done = 0; sym = '0;
    if (chg) begin
      restart_seq();
      if (inj) pend_m = 1;
    end else if (tick) begin
      e = hist[hist.size() - n_m] ^ hist[hist.size() - t_m];
      hist.push_back(e);
      if (hist.size() > 31) void'(hist.pop_front());
      raw_q.push_back(e);
      b = e ^ inv;
      pend_m = 0;
      exp_bv = 1; exp_bo = b; exp_ps = (cnt_m == 0);
      cnt_m = (cnt_m + 1) % ((longint'(1) << n_m) - 1);
      part.push_back(b);
      if (part.size() == bits_per(mod_c)) begin
        sym = make_symbol();
        part.delete();
        done = 1;
      end
    end else if (inj) begin
      pend_m = 1;
    end
    acc_now = mv && sym_ready;
    if (acc_now) void'(exp_q.pop_front());
    if (done) begin
      if (!mv || sym_ready) begin
        exp_q.push_back(sym);
        mv = 1;
      end else begin
        ovf_m = 1;
      end
    end else if (acc_now) begin
      mv = 0;
    end
  endtask

  task automatic compare();
    logic [2*WIDTH-1:0] s;
    check("bit_valid", 32'(bit_valid), 32'(exp_bv));
    check("pat_sync", 32'(pat_sync), 32'(exp_ps));
    if (exp_bv) check("bit_out", 32'(bit_out), 32'(exp_bo));
    check("sym_valid", 32'(sym_valid), 32'(mv));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (mv && exp_q.size() > 0) begin
      s = exp_q[0];
      check_w("i_out", i_out, s[2*WIDTH-1:WIDTH]);
      check_w("q_out", q_out, s[WIDTH-1:0]);
    end
    if (bit_valid) begin
      obs_bits.push_back(bit_out);
      bv_count++;
      if (pat_sync) ps_idx.push_back(obs_bits.size() - 1);
    end
    if (sym_valid && sym_ready) acc_i.push_back(i_out);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic clear_obs();
    obs_bits.delete();
    ps_idx.delete();
    raw_q.delete();
    acc_i.delete();
    bv_count = 0;
  endtask

  task automatic wait_sym_valid(input string tag);
    int guard;
    guard = 0;
    while (!sym_valid && guard < 40) begin
      cycle();
      guard++;
    end
    check(tag, 32'(sym_valid), 32'd1);
  endtask

  initial begin
    logic [6:0] first7;
    int diffs;
    int nbits;

    // Reset state
    pn_sel = 3'd0; mod_sel = 2'd0; gray = 1'b0; en = 1'b0;
    rate = ACC_W'(1) << (ACC_W - 1); sym_ready = 1'b1;
    do_reset();
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_pat_sync", 32'(pat_sync), 32'd0);
    check_w("rst_i_out", i_out, '0);
    check_w("rst_q_out", q_out, '0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // PN7 BPSK at half rate
    clear_obs();
    en = 1'b1;
    run(300);
    check("pn7_bv_count", 32'(bv_count), 32'((longint'(300) * longint'(rate)) >> ACC_W));
    first7 = '0;
    for (int j = 0; j < 7; j++) first7 = {first7[5:0], (j < obs_bits.size()) ? obs_bits[j] : 1'b1};
    check("pn7_first7", 32'(first7), 32'h01);
    check("pn7_ps_count", 32'(ps_idx.size()), 32'd2);
    if (ps_idx.size() == 2) begin
      check("pn7_ps_first", 32'(ps_idx[0]), 32'd0);
      check("pn7_ps_second", 32'(ps_idx[1]), 32'd127);
    end
    check("bpsk_sym_count", 32'(acc_i.size() >= 7), 32'd1);
    if (acc_i.size() >= 7) begin
      check_w("bpsk_sym1", acc_i[0], WIDTH'(-32767));
      check_w("bpsk_sym6", acc_i[5], WIDTH'(-32767));
      check_w("bpsk_sym7", acc_i[6], WIDTH'(32767));
    end

    // 16QAM with Gray mapping, then without
    mod_sel = 2'd2; gray = 1'b1;
    run(200);
    gray = 1'b0;
    run(200);

    // Backpressure with QPSK
    en = 1'b0; pn_sel = 3'd0; mod_sel = 2'd1; gray = 1'b0; sym_ready = 1'b0;
    do_reset();
    en = 1'b1;
    wait_sym_valid("bp_first_valid");
    run(12);
    check_w("bp_hold_i", i_out, WIDTH'(-32767));
    check_w("bp_hold_q", q_out, WIDTH'(-32767));
    check("bp_valid_held", 32'(sym_valid), 32'd1);
    check("bp_overflow", 32'(overflow), 32'd1);
    sym_ready = 1'b1;
    run(20);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("bp_overflow_cleared", 32'(overflow), 32'd0);

    // Mid-run configuration change with a symbol pending
    sym_ready = 1'b0;
    wait_sym_valid("cfg_first_valid");
    clear_obs();
    pn_sel = 3'd3;
    run(10);
    check("cfg_bits_seen", 32'(obs_bits.size() > 0), 32'd1);
    if (obs_bits.size() > 0) check("cfg_pn15_first", 32'(obs_bits[0]), 32'd0);
    check("cfg_ps_seen", 32'(ps_idx.size() > 0), 32'd1);
    if (ps_idx.size() > 0) check("cfg_ps_idx", 32'(ps_idx[0]), 32'd0);
    check_w("cfg_pending_i", i_out, WIDTH'(-32767));
    check("cfg_pending_valid", 32'(sym_valid), 32'd1);
    sym_ready = 1'b1;
    run(20);

    // Peak rate BPSK, ready held high
    mod_sel = 2'd0; rate = '1;
    run(100);
    check("peak_no_new_overflow", 32'(overflow), 32'(ovf_m));

    // Randomized segments
    for (int seg = 0; seg < 10; seg++) begin
      if (seg == 5) do_reset();
      pn_sel = 3'($urandom_range(0, 7));
      mod_sel = 2'($urandom_range(0, 3));
      gray = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rate = ACC_W'($urandom_range(0, 32'((longint'(1) << ACC_W) - 1)));
        1: rate = ACC_W'(1) << (ACC_W - 1);
        2: rate = '1;
        default: rate = ACC_W'($urandom_range(1, 4096));
      endcase
      for (int c = 0; c < 300; c++) begin
        en = ($urandom_range(0, 9) != 0);
        sym_ready = ($urandom_range(0, 9) < 8);
        cycle();
      end
    end

`ifdef PRBS_ERR_INJ_EN
    // Error injection: two pulses before one tick give one inverted bit
    en = 1'b0; pn_sel = 3'd0; mod_sel = 2'd0; gray = 1'b0; sym_ready = 1'b1;
    rate = ACC_W'(1) << (ACC_W - 2);
    do_reset();
    en = 1'b1;
    run(10);
    nbits = 0;
    while (!bit_valid && nbits < 10) begin
      cycle();
      nbits++;
    end
    check("inj_align", 32'(bit_valid), 32'd1);
    clear_obs();
    err_inj = 1'b1; cycle();
    err_inj = 1'b0; cycle();
    err_inj = 1'b1; cycle();
    err_inj = 1'b0;
    run(60);
    diffs = 0;
    for (int j = 0; j < obs_bits.size() && j < raw_q.size(); j++)
      if (obs_bits[j] != raw_q[j]) diffs++;
    check("inj_one_flip", 32'(diffs), 32'd1);
    check("inj_bit_count", 32'(obs_bits.size()), 32'(raw_q.size()));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_qam_src.md
# prbs_qam_src

Parametrised PRBS symbol source for the DSP test chain. It generates a selectable-length PRBS bit stream at a fractional bit rate from a phase accumulator. The bits are packed into BPSK/QPSK/16QAM/64QAM symbols with optional Gray mapping, and the symbols are delivered to the downstream pulse-shaping filter over a valid/ready handshake with overflow detection.

## Interface
- WIDTH, 16, signed I/Q sample width; legal range 4..16.
- ACC_W, 24, rate phase-accumulator width; legal range 8..32.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable; gates accumulator advance.
- rate  in  ACC_W  bit-rate increment; bit rate = f_clk·rate/2^ACC_W.
- pn_sel  in  3  PRBS polynomial select:
  - 0: PN7 x^7+x^6+1
  - 1: PN9 x^9+x^5+1
  - 2: PN11 x^11+x^9+1
  - 3: PN15 x^15+x^14+1
  - 4: PN23 x^23+x^18+1
  - 5: PN31 x^31+x^28+1
  - 6, 7: PN7
- mod_sel  in  2  bits per symbol: 0 BPSK (1), 1 QPSK (2), 2 16QAM (4), 3 64QAM (6).
- gray  in  1  1 = Gray-coded per-axis level index.
- err_inj  in  1  error-insert pulse (present only with PRBS_ERR_INJ_EN).
- bit_out  out  1  current PRBS bit.
- bit_valid  out  1  one-cycle strobe qualifying bit_out.
- pat_sync  out  1  strobe with the first bit of each PRBS period.
- i_out, q_out  out  WIDTH  signed symbol levels.
- sym_valid  out  1  symbol available.
- sym_ready  in  1  downstream accepts the symbol.
- overflow  out  1  sticky flag: a symbol was dropped.

## Operation
- **Accumulator:** when en=1, acc <= acc + rate (ACC_W bits). The carry-out is bit_tick. With en=0, acc holds; rate=0 produces no ticks.
- **LFSR:** 31-bit Fibonacci register; only the low n bits are used for PNn. On bit_tick: fb = s[n-1]^s[t-1], s <= {s[29:0], fb}, and the emitted bit = fb.
- **Config change:** pn_sel, mod_sel and gray are registered each cycle. Any change sets the LFSR to all-ones and clears the bit counter, the partial-symbol register and the period counter. sym_valid and overflow are unaffected.
- **Period counter:** counts bit_ticks 0..2^n-2, then wraps. pat_sync is asserted with the bit emitted when the counter is 0.
- **Symbol packing:** k = bits per symbol, split into kₐ bits per axis:
  - BPSK: kₐ=1, I only.
  - QPSK: kₐ=1.
  - 16QAM: kₐ=2.
  - 64QAM: kₐ=3.
  - The first emitted bit is the MSB of the I index. The I index takes the first kₐ bits, the Q index the next kₐ bits.
  - BPSK drives q_out = 0.
- **Gray mapping:** if gray=1, index m = gray-to-binary(bits); otherwise m = bits.
- **Level:** M = 2^kₐ, scale = floor((2^(WIDTH-1)-1)/(M-1)), level = (2m-(M-1))·scale. The result is computed in WIDTH+4 bits and is exact with no saturation. For WIDTH=16:
  - M=2: ±32767.
  - M=4: ±10922, ±32766.
  - M=8: ±4681·{1,3,5,7}.
- **Output register and handshake:**
  - A completed symbol is loaded if sym_valid=0, or if sym_valid & sym_ready in the same cycle; sym_valid then stays or becomes 1.
  - If sym_valid=1 and sym_ready=0, the new symbol is dropped and overflow <= 1 until rst.
  - i_out and q_out hold stable while sym_valid & !sym_ready.
  - When en=0, handshakes still complete and partial symbols are retained.

## Timing
- **Reset values:** acc=0, LFSR=all-ones, counters=0; bit_out, bit_valid, pat_sync, i_out, q_out, sym_valid and overflow are all 0.
- **Bit path:** bit_valid, bit_out and pat_sync are registered one cycle after the carry cycle.
- **Symbol path:** sym_valid rises one cycle after the bit_tick that completes the symbol, i.e. in the same cycle as that bit's bit_valid.
- **Acceptance:** the symbol is accepted on the rising clk with sym_valid & sym_ready. sym_valid falls in the next cycle unless a new symbol loads in that same cycle.
- **Peak rate:** at rate=2^ACC_W-1, nearly every cycle ticks. BPSK then requires sym_ready held high to avoid overflow.
- **Reset precedence:** rst overrides every other event, including mid-symbol and mid-handshake.

## Configuration
- **PRBS_ERR_INJ_EN defined:**
  - The err_inj port exists.
  - A pulse sets a pending flag, and the next emitted bit is inverted on bit_out and in symbol packing. The LFSR state and the period counter are unaffected.
  - The flag clears on that tick. Multiple pulses before the tick collapse to one inversion.
  - A pulse coincident with a tick applies to that tick.
- **PRBS_ERR_INJ_EN undefined:** port absent, no inversion logic.

## Test plan
- **PN7 sequence:** rst, pn_sel=0, mod_sel=0, rate=2^(ACC_W-1), sym_ready=1 -> bit_valid every 2 cycles. First bits are 0,0,0,0,0,0,1 with pat_sync on bit 1; period 127, pat_sync repeats at bit 128.
- **BPSK levels:** same setup, WIDTH=16 -> first six symbols i_out=-32767, seventh +32767, q_out=0.
- **16QAM Gray:** mod_sel=2, gray=1, bits 1,0,1,1 forced via a PN preload scenario -> I m=3 -> +32766, Q m=2 -> +10922. With gray=0: I=+10922, Q=+32766.
- **Backpressure:** QPSK with sym_ready=0 for three symbol periods -> first symbol held stable, second dropped, overflow=1 until rst, sym_valid held throughout.
- **Mid-run config change:** pn_sel 0->3 while en=1 -> the next bit follows the PN15 all-ones sequence, pat_sync on that bit, and the pending output symbol is preserved.
- **Error injection:** with PRBS_ERR_INJ_EN, err_inj pulsed twice between ticks -> exactly one inverted bit. The bits that follow match the uninjected reference sequence.
